// File: rtl/rgmii_tx_framer.sv
// GMII transmit framer: preamble, SFD, payload, zero pad, FCS and inter-frame gap, one byte per mac_clk.
// Registered outputs: an accepted byte appears one cycle later; mac_ready drops outside DATA/ABORT/stray-drop.
module rgmii_tx_framer #(
   parameter int DATA_WIDTH = 8,
   parameter int MIN_FRAME  = 60,
   parameter int IFG_BYTES  = 12,
   parameter int SIM        = 0
) (
   input  logic       mac_clk,
   input  logic       mac_rst,
   input  logic       mac_startofpacket,
   input  logic       mac_endofpacket,
   input  logic       mac_valid,
   input  logic [7:0] mac_data,
   input  logic       mac_error,
   output logic       mac_ready,
   output logic [7:0] gmii_tx_data,
   output logic       gmii_tx_en,
   output logic       gmii_tx_er
);

   localparam int          IFG_LEN  = (SIM != 0) ? 2 : IFG_BYTES;
   localparam logic [15:0] MIN_CNT  = 16'(MIN_FRAME);
   localparam logic [15:0] IFG_LAST = 16'(IFG_LEN - 1);

   if (DATA_WIDTH != 8) begin : g_width_check
      $error("rgmii_tx_framer supports DATA_WIDTH = 8 only");
   end
   if (IFG_BYTES < 1) begin : g_ifg_check
      $error("rgmii_tx_framer requires IFG_BYTES >= 1");
   end

   typedef enum logic [2:0] {
      S_IDLE, S_PREAMBLE, S_SFD, S_DATA, S_PAD, S_FCS, S_IFG, S_ABORT
   } state_t;

   state_t      state, state_nxt;
   logic [15:0] step, step_nxt;
   logic [15:0] byte_cnt, byte_cnt_nxt, byte_inc;
   logic [31:0] crc, crc_nxt, crc_inv;
   logic [7:0]  data_nxt;
   logic        en_nxt, er_nxt, ready_c;

   // Reflected CRC-32, data bits taken LSB first.
   function automatic logic [31:0] crc32_byte(input logic [31:0] c_in, input logic [7:0] d);
      logic [31:0] c;
      c = c_in;
      for (int i = 0; i < 8; i++) begin
         if (c[0] ^ d[i]) c = (c >> 1) ^ 32'hEDB88320;
         else             c = c >> 1;
      end
      return c;
   endfunction

   assign byte_inc  = (byte_cnt == 16'hFFFF) ? byte_cnt : byte_cnt + 16'd1;
   assign crc_inv   = ~crc;
   assign mac_ready = ready_c & ~mac_rst;

   always_ff @(posedge mac_clk or posedge mac_rst) begin
      if (mac_rst) begin
         state        <= S_IDLE;
         step         <= '0;
         byte_cnt     <= '0;
         crc          <= 32'hFFFFFFFF;
         gmii_tx_data <= '0;
         gmii_tx_en   <= 1'b0;
         gmii_tx_er   <= 1'b0;
      end else begin
         state        <= state_nxt;
         step         <= step_nxt;
         byte_cnt     <= byte_cnt_nxt;
         crc          <= crc_nxt;
         gmii_tx_data <= data_nxt;
         gmii_tx_en   <= en_nxt;
         gmii_tx_er   <= er_nxt;
      end
   end

   always_comb begin
      state_nxt    = state;
      step_nxt     = step;
      byte_cnt_nxt = byte_cnt;
      crc_nxt      = crc;
      data_nxt     = 8'h00;
      en_nxt       = 1'b0;
      er_nxt       = 1'b0;
      ready_c      = 1'b0;
      case (state)
         S_IDLE: begin
            // The SOP byte stays on the bus until DATA; only stray bytes are eaten here.
            ready_c = mac_valid && !mac_startofpacket;
            if (mac_valid && mac_startofpacket) begin
               en_nxt    = 1'b1;
               data_nxt  = 8'h55;
               step_nxt  = 16'd1;
               state_nxt = S_PREAMBLE;
            end
         end
         S_PREAMBLE: begin
            en_nxt   = 1'b1;
            data_nxt = 8'h55;
            if (step == 16'd6) state_nxt = S_SFD;
            else               step_nxt  = step + 16'd1;
         end
         S_SFD: begin
            en_nxt       = 1'b1;
            data_nxt     = 8'hD5;
            crc_nxt      = 32'hFFFFFFFF;
            byte_cnt_nxt = '0;
            state_nxt    = S_DATA;
         end
         S_DATA: begin
            ready_c = 1'b1;
            en_nxt  = 1'b1;
            if (mac_valid) begin
               data_nxt     = mac_data;
               er_nxt       = mac_error;
               crc_nxt      = crc32_byte(crc, mac_data);
               byte_cnt_nxt = byte_inc;
               if (mac_endofpacket) begin
                  step_nxt  = '0;
                  state_nxt = (byte_inc < MIN_CNT) ? S_PAD : S_FCS;
               end
            end else begin
               // Source ran dry mid-frame: poison this slot and drop the rest of the frame.
               er_nxt    = 1'b1;
               state_nxt = S_ABORT;
            end
         end
         S_PAD: begin
            en_nxt       = 1'b1;
            crc_nxt      = crc32_byte(crc, 8'h00);
            byte_cnt_nxt = byte_inc;
            if (byte_inc >= MIN_CNT) begin
               step_nxt  = '0;
               state_nxt = S_FCS;
            end
         end
         S_FCS: begin
            en_nxt   = 1'b1;
            data_nxt = crc_inv[{step[1:0], 3'b000} +: 8];
            if (step == 16'd3) begin
               step_nxt  = '0;
               state_nxt = S_IFG;
            end else begin
               step_nxt = step + 16'd1;
            end
         end
         S_IFG: begin
            if (step == IFG_LAST) begin
               step_nxt  = '0;
               state_nxt = S_IDLE;
            end else begin
               step_nxt = step + 16'd1;
            end
         end
         S_ABORT: begin
            ready_c = 1'b1;
            if (mac_valid && mac_endofpacket) begin
               step_nxt  = '0;
               state_nxt = S_IFG;
            end
         end
         default: state_nxt = S_IDLE;
      endcase
   end

endmodule

// File: tb/tb_rgmii_tx_framer.sv
// Bench for rgmii_tx_framer: frame-level reference model feeding an expected-byte queue.
module tb_rgmii_tx_framer;

   localparam int MIN_FRAME = 60;
   localparam int IFG       = 12;

   logic       mac_clk = 1'b0;
   logic       mac_rst = 1'b0;
   logic       mac_startofpacket = 1'b0;
   logic       mac_endofpacket = 1'b0;
   logic       mac_valid = 1'b0;
   logic [7:0] mac_data = 8'h00;
   logic       mac_error = 1'b0;
   logic       mac_ready;
   logic [7:0] gmii_tx_data;
   logic       gmii_tx_en;
   logic       gmii_tx_er;

   always #4 mac_clk = ~mac_clk;

   rgmii_tx_framer #(
      .DATA_WIDTH(8), .MIN_FRAME(MIN_FRAME), .IFG_BYTES(IFG), .SIM(0)
   ) dut (
      .mac_clk(mac_clk), .mac_rst(mac_rst),
      .mac_startofpacket(mac_startofpacket), .mac_endofpacket(mac_endofpacket),
      .mac_valid(mac_valid), .mac_data(mac_data), .mac_error(mac_error),
      .mac_ready(mac_ready),
      .gmii_tx_data(gmii_tx_data), .gmii_tx_en(gmii_tx_en), .gmii_tx_er(gmii_tx_er)
   );

   typedef logic [7:0] byte_q_t[$];
   typedef struct packed { logic [7:0] d; logic er; logic last; } exp_t;

   exp_t exp_q[$];
   int   len_q[$];
   int   errors = 0, checks = 0;
   int   run_len = 0, last_run = 0, low_cnt = 0, er_cnt = 0, exp_gap = -1;
   bit   in_frame = 0, have_fall = 0, cmp_on = 0;

   task automatic chk(input bit ok, input string name, input longint act, input longint req);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
      end
   endtask

   function automatic logic [31:0] fcs_of(input byte_q_t q);
      logic [31:0] c = 32'hFFFFFFFF;
      foreach (q[i]) begin
         c = c ^ {24'h0, q[i]};
         repeat (8) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
      end
      return ~c;
   endfunction

   function automatic void push_exp(input logic [7:0] d, input logic er, input logic last);
      exp_t e;
      e.d = d; e.er = er; e.last = last;
      exp_q.push_back(e);
   endfunction

   // Whole-frame expectation: what the wire must carry for this payload.
   function automatic int model_frame(input byte_q_t pl, input int err_idx, input int uf_idx);
      byte_q_t     body;
      logic [31:0] fcs;
      int          n;
      for (int i = 0; i < 7; i++) push_exp(8'h55, 1'b0, 1'b0);
      push_exp(8'hD5, 1'b0, 1'b0);
      if (uf_idx >= 0) begin
         for (int i = 0; i < uf_idx; i++) push_exp(pl[i], i == err_idx, 1'b0);
         push_exp(8'h00, 1'b1, 1'b1);
         n = 8 + uf_idx + 1;
      end else begin
         body = pl;
         while (body.size() < MIN_FRAME) body.push_back(8'h00);
         foreach (body[i]) push_exp(body[i], i == err_idx, 1'b0);
         fcs = fcs_of(body);
         for (int k = 0; k < 4; k++) push_exp(fcs[8*k +: 8], 1'b0, k == 3);
         n = 8 + body.size() + 4;
      end
      len_q.push_back(n);
      return n;
   endfunction

   task automatic send_frame(input byte_q_t pl, input int err_idx, input int uf_idx,
                             input int stop_idx, output int mlen);
      int idx = 0, cyc = 0, n;
      bit dropped = 0, acc;
      n    = pl.size();
      mlen = model_frame(pl, err_idx, uf_idx);
      @(negedge mac_clk);
      while (idx < n) begin
         if (idx == uf_idx && !dropped) begin
            mac_valid = 1'b0; mac_startofpacket = 1'b0; mac_endofpacket = 1'b0; mac_error = 1'b0;
            dropped = 1;
         end else begin
            mac_valid = 1'b1;
            mac_startofpacket = (idx == 0);
            mac_endofpacket   = (idx == n - 1);
            mac_data          = pl[idx];
            mac_error         = (idx == err_idx);
         end
         if (idx == stop_idx) return;
         #1 acc = mac_valid && mac_ready;
         @(posedge mac_clk);
         if (acc) idx++;
         cyc++;
         if (cyc > 2000) begin
            chk(1'b0, "input handshake timeout", idx, n);
            mac_valid = 1'b0;
            return;
         end
         if (idx < n) @(negedge mac_clk);
      end
   endtask

   task automatic idle(input int k);
      @(negedge mac_clk);
      mac_valid = 1'b0; mac_startofpacket = 1'b0; mac_endofpacket = 1'b0; mac_error = 1'b0;
      repeat (k - 1) @(negedge mac_clk);
   endtask

   task automatic wait_drain();
      int t = 0;
      while ((exp_q.size() != 0 || gmii_tx_en) && t < 3000) begin
         @(negedge mac_clk);
         t++;
      end
      chk(t < 3000, "drain timeout", t, 3000);
      repeat (2) @(negedge mac_clk);
      #1;
   endtask

   function automatic byte_q_t ramp(input int n, input logic [7:0] first);
      byte_q_t q;
      for (int i = 0; i < n; i++) q.push_back(first + 8'(i));
      return q;
   endfunction

   function automatic byte_q_t rnd_bytes(input int n);
      byte_q_t q;
      for (int i = 0; i < n; i++) q.push_back(8'($urandom));
      return q;
   endfunction

   // Per-cycle output checker.
   initial begin
      exp_t e;
      int   want_len;
      forever begin
         @(negedge mac_clk);
         if (!mac_rst && cmp_on) begin
            if (gmii_tx_en) begin
               if (run_len == 0 && have_fall) begin
                  if (exp_gap >= 0) chk(low_cnt == exp_gap, "ifg exact", low_cnt, exp_gap);
                  else              chk(low_cnt >= IFG, "ifg minimum", low_cnt, IFG);
                  have_fall = 0;
               end
               run_len++;
               if (gmii_tx_er) er_cnt++;
               chk(exp_q.size() > 0, "unexpected tx_en", gmii_tx_data, 0);
               if (exp_q.size() > 0) begin
                  e = exp_q.pop_front();
                  chk({gmii_tx_data, gmii_tx_er} == {e.d, e.er}, "tx data/er",
                      {gmii_tx_data, gmii_tx_er}, {e.d, e.er});
                  in_frame = !e.last;
               end
            end else begin
               chk(!in_frame && gmii_tx_data == 8'h00 && !gmii_tx_er, "idle outputs/contiguous",
                   {in_frame, gmii_tx_er, gmii_tx_data}, 0);
               in_frame = 0;
               if (run_len > 0) begin
                  last_run = run_len;
                  if (len_q.size() > 0) begin
                     want_len = len_q.pop_front();
                     chk(run_len == want_len, "tx_en length", run_len, want_len);
                  end
                  run_len   = 0;
                  have_fall = 1;
                  low_cnt   = 0;
               end
               low_cnt++;
            end
         end
      end
   end

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
      $fatal(1, "watchdog");
   end

   initial begin
      byte_q_t pl;
      int      mlen, er0;
      bit      prev_good;

      #1 mac_rst = 1'b1;
      repeat (3) @(negedge mac_clk);
      mac_valid = 1'b1;
      #1;
      chk(gmii_tx_data == 8'h00, "reset tx_data", gmii_tx_data, 0);
      chk(gmii_tx_en == 1'b0, "reset tx_en", gmii_tx_en, 0);
      chk(gmii_tx_er == 1'b0, "reset tx_er", gmii_tx_er, 0);
      chk(mac_ready == 1'b0, "reset mac_ready", mac_ready, 0);
      mac_valid = 1'b0;
      @(negedge mac_clk);
      #2 mac_rst = 1'b0;
      cmp_on = 1;

      pl = ramp(9, 8'h31);
      chk(fcs_of(pl) == 32'hCBF43926, "crc check value", fcs_of(pl), 32'hCBF43926);

      // 9-byte frame padded to minimum length
      send_frame(pl, -1, -1, -1, mlen);
      chk(mlen == 72, "model len 9B", mlen, 72);
      wait_drain();
      chk(last_run == 72, "tx_en cycles 9B", last_run, 72);
      idle(20);

      // 64-byte frame, then a 100-byte frame that underflows after byte 20, sent back-to-back
      send_frame(ramp(64, 8'h00), -1, -1, -1, mlen);
      chk(mlen == 76, "model len 64B", mlen, 76);
      exp_gap = IFG;
      send_frame(rnd_bytes(100), -1, 20, -1, mlen);
      exp_gap = -1;
      chk(mlen == 29, "model len underflow", mlen, 29);
      wait_drain();
      chk(last_run == 29, "tx_en cycles underflow", last_run, 29);
      idle(5);

      // Two frames, second SOP waiting during the first one's FCS
      send_frame(rnd_bytes(30), -1, -1, -1, mlen);
      exp_gap = IFG;
      send_frame(rnd_bytes(70), -1, -1, -1, mlen);
      exp_gap = -1;
      wait_drain();
      chk(last_run == 82, "tx_en cycles 70B", last_run, 82);
      idle(15);

      // Source error flag on byte 5
      er0 = er_cnt;
      send_frame(rnd_bytes(40), 4, -1, -1, mlen);
      wait_drain();
      chk(er_cnt - er0 == 1, "single tx_er", er_cnt - er0, 1);
      idle(15);

      // Reset while byte 30 is presented, then a fresh 60-byte frame
      send_frame(rnd_bytes(50), -1, -1, 29, mlen);
      #2 mac_rst = 1'b1;
      #1;
      chk({gmii_tx_en, gmii_tx_er, gmii_tx_data} == 10'd0, "mid-frame reset outputs",
          {gmii_tx_en, gmii_tx_er, gmii_tx_data}, 0);
      chk(mac_ready == 1'b0, "mid-frame reset ready", mac_ready, 0);
      exp_q.delete(); len_q.delete();
      run_len = 0; in_frame = 0; have_fall = 0;
      mac_valid = 1'b0; mac_startofpacket = 1'b0; mac_endofpacket = 1'b0; mac_error = 1'b0;
      repeat (3) @(negedge mac_clk);
      #2 mac_rst = 1'b0;
      send_frame(rnd_bytes(60), -1, -1, -1, mlen);
      wait_drain();
      chk(last_run == 72, "tx_en cycles after reset", last_run, 72);
      idle(15);

      // Stray non-SOP bytes in IDLE are accepted and dropped
      for (int i = 0; i < 3; i++) begin
         @(negedge mac_clk);
         mac_valid = 1'b1; mac_startofpacket = 1'b0; mac_endofpacket = (i == 2);
         mac_data = 8'hA0 + 8'(i);
         #1 chk(mac_ready == 1'b1, "stray byte ready", mac_ready, 1);
      end
      idle(5);

      // Randomized frames
      prev_good = 0;
      for (int f = 0; f < 24; f++) begin
         int n, err, uf, gap;
         n   = (f == 0) ? 1 : $urandom_range(1, 120);
         err = ($urandom_range(0, 3) == 0) ? $urandom_range(0, n - 1) : -1;
         uf  = (n >= 2 && $urandom_range(0, 5) == 0) ? $urandom_range(1, n - 1) : -1;
         gap = ($urandom_range(0, 2) == 0) ? 0 : $urandom_range(1, 20);
         if (gap > 0) idle(gap);
         exp_gap = (gap == 0 && prev_good) ? IFG : -1;
         send_frame(rnd_bytes(n), err, uf, -1, mlen);
         prev_good = (uf < 0);
      end
      exp_gap = -1;
      wait_drain();
      idle(20);
      chk(exp_q.size() == 0, "expected queue empty", exp_q.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
